// File: rtl/nibble_seq_pkg.sv
// Shared types and constants for the nibble sequencer: FSM state encoding,
// nibble width and the modulo-16 increment helper.
package nibble_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Natural overflow of the nibble-wide add gives the modulo-16 wrap.
    function automatic logic [NIBBLE_W-1:0] nibble_next(input logic [NIBBLE_W-1:0] value);
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, counting debouncer and a
// registered one-cycle press pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] count;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle;
    // the press pulse is raised in the same edge, so it appears one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                level <= sync_b;
                count <= '0;
                press <= sync_b;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nibble_sequencer.sv
// Nibble sequencer: debounced step/run buttons drive a 4-bit counter either
// manually (IDLE) or from a free-running prescaler (RUN).
module nibble_sequencer
    import nibble_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_step,
    input  logic                btn_run,
    output logic [NIBBLE_W-1:0] a_out,
    output logic                valid,
    output logic                wrap,
    output logic                running
);

    localparam int PS_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RUN_DIV - 1);

    logic            step_press;
    logic            run_press;
    seq_state_t      state;
    logic [PS_W-1:0] prescale;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_step),
        .press(step_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_run),
        .press(run_press)
    );

    // A run press always wins: it drops a coincident step press and
    // suppresses a coincident prescaler terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prescale <= '0;
            a_out    <= '0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
            running  <= 1'b0;
        end else begin
            valid <= 1'b0;
            wrap  <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_press) begin
                        state    <= RUN;
                        running  <= 1'b1;
                        prescale <= '0;
                    end else if (step_press) begin
                        a_out <= nibble_next(a_out);
                        valid <= 1'b1;
                        wrap  <= (a_out == '1);
                    end
                end
                RUN: begin
                    if (run_press) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (prescale == PS_LAST) begin
                        prescale <= '0;
                        a_out    <= nibble_next(a_out);
                        valid    <= 1'b1;
                        wrap     <= (a_out == '1);
                    end else begin
                        prescale <= prescale + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_sequencer.sv
// Self-checking bench for nibble_sequencer: directed scenarios plus random
// button activity, all compared every cycle against a behavioural model.
module tb_nibble_sequencer;

    localparam int DB = 4;
    localparam int RD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_step;
    logic       btn_run;
    logic [3:0] a_out;
    logic       valid;
    logic       wrap;
    logic       running;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    nibble_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (RD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_step(btn_step),
        .btn_run (btn_run),
        .a_out   (a_out),
        .valid   (valid),
        .wrap    (wrap),
        .running (running)
    );

    // Model state: raw button history per edge, accepted levels, pending
    // presses, mode and the edge at which RUN was last entered.
    bit         q_step[$];
    bit         q_run[$];
    bit         deb_step;
    bit         deb_run;
    bit         pend_step;
    bit         pend_run;
    bit         mode_run;
    int         edge_n;
    int         entry_edge;
    logic [3:0] a_m;
    logic       valid_m;
    logic       wrap_m;

    int         ticks;
    int         change_at;
    logic [3:0] prev_a;
    int         valid_seen;
    int         wrap_seen;

    function automatic bit seen_at(input bit q[$], input int back);
        int idx = q.size() - 1 - back;
        if (idx < 0) return 1'b0;
        return q[idx];
    endfunction

    // A level is accepted once DB consecutive synchronized samples (raw
    // delayed by two edges) all disagree with the current accepted level.
    function automatic bit window_differs(input bit q[$], input bit deb);
        for (int i = 2; i < DB + 2; i++) begin
            if (seen_at(q, i) == deb) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q_step.delete();
        q_run.delete();
        deb_step   = 1'b0;
        deb_run    = 1'b0;
        pend_step  = 1'b0;
        pend_run   = 1'b0;
        mode_run   = 1'b0;
        edge_n     = 0;
        entry_edge = 0;
        a_m        = 4'h0;
        valid_m    = 1'b0;
        wrap_m     = 1'b0;
    endtask

    task automatic bump();
        wrap_m  = (a_m == 4'hF);
        a_m     = (a_m == 4'hF) ? 4'h0 : a_m + 4'h1;
        valid_m = 1'b1;
    endtask

    task automatic model_edge();
        edge_n++;
        valid_m = 1'b0;
        wrap_m  = 1'b0;
        if (pend_run) begin
            mode_run = !mode_run;
            if (mode_run) entry_edge = edge_n;
        end else if (!mode_run && pend_step) begin
            bump();
        end else if (mode_run && ((edge_n - entry_edge) % RD == 0)) begin
            bump();
        end
        q_step.push_back(btn_step);
        q_run.push_back(btn_run);
        if (q_step.size() > DB + 3) void'(q_step.pop_front());
        if (q_run.size() > DB + 3) void'(q_run.pop_front());
        pend_step = 1'b0;
        if (window_differs(q_step, deb_step)) begin
            deb_step  = !deb_step;
            pend_step = deb_step;
        end
        pend_run = 1'b0;
        if (window_differs(q_run, deb_run)) begin
            deb_run  = !deb_run;
            pend_run = deb_run;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b1) model_edge();
        else model_reset();
        ticks++;
        @(negedge clk);
        checkOutput("a_out", 32'(a_out), 32'(a_m));
        checkOutput("valid", 32'(valid), 32'(valid_m));
        checkOutput("wrap", 32'(wrap), 32'(wrap_m));
        checkOutput("running", 32'(running), 32'(mode_run));
        if (valid === 1'b1) valid_seen++;
        if (wrap === 1'b1) wrap_seen++;
        if (change_at < 0 && a_out !== prev_a) change_at = ticks;
        prev_a = a_out;
    endtask

    task automatic applyStimulus(input logic step, input logic run, input int cycles);
        btn_step = step;
        btn_run  = run;
        repeat (cycles) tick();
    endtask

    task automatic resetDut();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset a_out", 32'(a_out), 32'h0);
        checkOutput("reset valid", 32'(valid), 32'h0);
        checkOutput("reset wrap", 32'(wrap), 32'h0);
        checkOutput("reset running", 32'(running), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n      = 1'b1;
        btn_step   = 1'b0;
        btn_run    = 1'b0;
        ticks      = 0;
        change_at  = -1;
        prev_a     = 4'h0;
        valid_seen = 0;
        wrap_seen  = 0;
        model_reset();
        @(negedge clk);
        resetDut();

        // Held step button: single increment after DB+3 edges, no repeats.
        ticks = 0;
        change_at = -1;
        valid_seen = 0;
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("step latency", 32'(change_at), 32'd7);
        checkOutput("held press count", 32'(valid_seen), 32'd1);
        checkOutput("held a_out", 32'(a_out), 32'h1);

        // Glitches shorter than DB cycles are rejected.
        resetDut();
        valid_seen = 0;
        repeat (5) begin
            applyStimulus(1'b1, 1'b0, 3);
            applyStimulus(1'b0, 1'b0, 3);
        end
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("glitch valid count", 32'(valid_seen), 32'd0);
        checkOutput("glitch a_out", 32'(a_out), 32'h0);

        // Sixteen clean presses wrap the nibble exactly once.
        valid_seen = 0;
        wrap_seen  = 0;
        repeat (16) begin
            applyStimulus(1'b1, 1'b0, 8);
            applyStimulus(1'b0, 1'b0, 8);
        end
        checkOutput("16 press valid count", 32'(valid_seen), 32'd16);
        checkOutput("16 press wrap count", 32'(wrap_seen), 32'd1);
        checkOutput("16 press a_out", 32'(a_out), 32'h0);

        // RUN mode: entry lands on tick 7 of the run press; step press is ignored.
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 26);
        checkOutput("run 40 a_out", 32'(a_out), 32'h5);
        checkOutput("run 40 running", 32'(running), 32'h1);
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("stop running", 32'(running), 32'h0);
        checkOutput("stop frozen a_out", 32'(a_out), 32'h5);

        // Asynchronous reset in RUN with a_out at 9.
        applyStimulus(1'b0, 1'b1, 8);
        btn_run = 1'b0;
        guard = 0;
        while (a_m != 4'h9 && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("run reaches 9", 32'(a_out), 32'h9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async a_out", 32'(a_out), 32'h0);
        checkOutput("async valid", 32'(valid), 32'h0);
        checkOutput("async wrap", 32'(wrap), 32'h0);
        checkOutput("async running", 32'(running), 32'h0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("post reset running", 32'(running), 32'h0);

        // Step held through reset counts as a fresh press after release.
        btn_step = 1'b1;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        ticks = 0;
        change_at = -1;
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("held through reset latency", 32'(change_at), 32'd7);
        checkOutput("held through reset a_out", 32'(a_out), 32'h1);

        // Simultaneous run and step press: only the mode toggle is taken.
        applyStimulus(1'b1, 1'b1, 8);
        checkOutput("simultaneous running", 32'(running), 32'h1);
        checkOutput("simultaneous a_out", 32'(a_out), 32'h1);
        applyStimulus(1'b0, 1'b0, 8);
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 8);

        // Random button activity mixing glitches and long holds.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 11) == 0) btn_run = ~btn_run;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nibble_sequencer.md
NIBBLE_SEQUENCER -- requirements
Module: nibble_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, consecutive stable cycles before a synchronized button level is accepted (range 2..65535).
REQ-002 Parameter: RUN_DIV, 8, clock cycles between automatic increments in RUN mode (range 2..2^24).
REQ-003 Port: clk  input  1  single system clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: btn_step  input  1  raw asynchronous step pushbutton, active-high.
REQ-006 Port: btn_run  input  1  raw asynchronous run/stop toggle pushbutton, active-high.
REQ-007 Port: a_out  output  4  current nibble; drives the 4-bit input `a` of the LED decode stage.
REQ-008 Port: valid  output  1  one-cycle pulse coincident with each change of a_out.
REQ-009 Port: wrap  output  1  one-cycle pulse coincident with a_out changing from 4'hF to 4'h0.
REQ-010 Port: running  output  1  high while the FSM is in RUN.

Function
REQ-011 Each button passes through a 2-flop synchronizer, then a debouncer with a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-012 Debouncer: the counter clears whenever the synchronized level equals the debounced level, and otherwise increments; when it reaches DEBOUNCE_CYCLES the debounced level flips and the counter clears.
REQ-013 Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change in the debounced level and no press.
REQ-014 Press = registered rising edge of the debounced level; one press per physical press; a held button produces no repeats; a release produces no action.
REQ-015 Latency: a_out updates DEBOUNCE_CYCLES+3 rising edges after the first edge that samples btn_step high, provided btn_step is held stable throughout.
REQ-016 FSM states: IDLE (manual mode) and RUN (auto mode).
REQ-017 IDLE->RUN on a run press; RUN->IDLE on a run press; no other transitions.
REQ-018 In IDLE, a step press increments a_out by 1 on the press cycle.
REQ-019 In RUN, step presses are ignored.
REQ-020 On RUN entry, the prescaler clears to 0; it counts 0..RUN_DIV-1, and at RUN_DIV-1 it increments a_out and restarts, so the first increment occurs RUN_DIV cycles after entry.
REQ-021 On RUN exit, the prescaler freezes and is cleared on the next entry; a_out holds its value.
REQ-022 Increment is modulo 16: 4'hF+1 = 4'h0, and wrap asserts in that same cycle together with valid.
REQ-023 Simultaneous run press and step press in the same cycle: only the run toggle is taken; the step press is dropped.
REQ-024 A run press coinciding with the prescaler terminal count: the mode toggles and no increment occurs in that cycle.
REQ-025 valid and wrap are registered and low in every cycle in which a_out does not change.

Reset
REQ-026 While rst_n=0, all outputs and state are forced immediately (asynchronously): a_out=4'h0, valid=0, wrap=0, running=0, FSM=IDLE, prescaler=0, synchronizers=0, debounced levels=0, debounce counters=0.
REQ-027 A reset asserted mid-debounce or mid-prescale discards all partial counts.
REQ-028 A button held high through reset release is treated as a new press once it has been stable for DEBOUNCE_CYCLES.

Structure
REQ-029 Package nibble_seq_pkg holds the FSM state type (IDLE, RUN) and the nibble width constant (4).
REQ-030 One sub-module, btn_debounce (synchronizer, debouncer and press-pulse generator, parameterized by DEBOUNCE_CYCLES), is instantiated once for btn_step and once for btn_run.
REQ-031 The top level contains the FSM, the prescaler and the a_out register only.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=8, 10 ns clock)
REQ-032 Reset, then hold btn_step high for 10 cycles -> a_out 0->1 exactly 7 edges after the first high sample, valid pulses once, and no further change while held.
REQ-033 btn_step high for 3 cycles, low for 3 cycles, repeated 5 times -> a_out stays 4'h0 and valid never asserts.
REQ-034 16 clean step presses from a_out=4'h0 -> a_out returns to 4'h0, wrap pulses exactly once (on the 16th press), and valid pulses 16 times.
REQ-035 Run press, wait 40 cycles -> running=1, a_out=5 with increments every 8 cycles; a second run press then freezes a_out and deasserts running.
REQ-036 In RUN, press btn_step -> no change in a_out beyond prescaler-driven increments.
REQ-037 Drive rst_n=0 asynchronously mid-run with a_out=4'h9 -> outputs are 0 immediately, before the next clock edge; after release, FSM=IDLE and running=0.
